// File: rtl/alu_arbiter_pkg.sv
// Shared pipeline types: ALU operation encoding and arbiter requester index.
package PipeTypes;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9
   } alu_op_t;

   localparam int ARB_NUM_REQ = 2;

   typedef logic [$clog2(ARB_NUM_REQ)-1:0] arb_src_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 32-bit ALU; unknown op codes yield zero.
module alu
   import PipeTypes::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  alu_op_t     op,
   output logic [31:0] y
);

   always_comb begin
      // NOTE: default assignment first so every path drives y and no latch is inferred.
      y = '0;
      case (op)
         ALU_ADD:  y = a + b;
         ALU_SUB:  y = a - b;
         ALU_SLL:  y = a << b[4:0];
         ALU_SLT:  y = {31'b0, $signed(a) < $signed(b)};
         ALU_SLTU: y = {31'b0, a < b};
         ALU_XOR:  y = a ^ b;
         ALU_SRL:  y = a >> b[4:0];
         ALU_SRA:  y = $signed(a) >>> b[4:0];
         ALU_OR:   y = a | b;
         ALU_AND:  y = a & b;
         default:  y = '0;
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end to one shared ALU with a single result register.
module alu_arbiter
   import PipeTypes::*;
#(
   parameter int TAG_W = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             req0_valid_i,
   output logic             req0_ready_o,
   input  logic [31:0]      req0_a_i,
   input  logic [31:0]      req0_b_i,
   input  alu_op_t          req0_op_i,
   input  logic [TAG_W-1:0] req0_tag_i,
   input  logic             req1_valid_i,
   output logic             req1_ready_o,
   input  logic [31:0]      req1_a_i,
   input  logic [31:0]      req1_b_i,
   input  alu_op_t          req1_op_i,
   input  logic [TAG_W-1:0] req1_tag_i,
   output logic             res_valid_o,
   input  logic             res_ready_i,
   output logic [31:0]      res_data_o,
   output arb_src_t         res_src_o,
   output logic [TAG_W-1:0] res_tag_o
);

   arb_src_t         rr_last;
   arb_src_t         grant;
   logic             accept;
   logic             xfer;
   logic [31:0]      alu_a;
   logic [31:0]      alu_b;
   alu_op_t          alu_op;
   logic [31:0]      alu_y;
   logic [TAG_W-1:0] grant_tag;

   assign accept = !res_valid_o || res_ready_i;

   // On a tie the requester that did not win last time goes next.
   always_comb begin
      grant = '0;
      if (req0_valid_i && req1_valid_i) grant = ~rr_last;
      else if (req1_valid_i)            grant = 1'b1;
   end

   assign req0_ready_o = !rst_i && accept && (grant == 1'b0);
   assign req1_ready_o = !rst_i && accept && (grant == 1'b1);
   assign xfer = (req0_valid_i && req0_ready_o) || (req1_valid_i && req1_ready_o);

   assign alu_a     = grant ? req1_a_i   : req0_a_i;
   assign alu_b     = grant ? req1_b_i   : req0_b_i;
   assign alu_op    = grant ? req1_op_i  : req0_op_i;
   assign grant_tag = grant ? req1_tag_i : req0_tag_i;

   alu u_alu (
      .a  (alu_a),
      .b  (alu_b),
      .op (alu_op),
      .y  (alu_y)
   );

   always_ff @(posedge clk_i) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (rst_i) begin
         res_valid_o <= 1'b0;
         res_data_o  <= '0;
         res_src_o   <= '0;
         res_tag_o   <= '0;
         rr_last     <= 1'b1;
      end else if (accept) begin
         res_valid_o <= xfer;
         if (xfer) begin
            res_data_o <= alu_y;
            res_src_o  <= grant;
            res_tag_o  <= grant_tag;
            rr_last    <= grant;
         end
      end
   end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 TAG_W, default 4: width of the requester tag returned with each result.
REQ-002 clk_i  input  1  rising-edge clock; the only clock domain.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 reqN_valid_i (N=0,1)  input  1  requester N presents an operation.
REQ-005 reqN_ready_o (N=0,1)  output  1  arbiter accepts requester N's operation this cycle.
REQ-006 reqN_a_i (N=0,1)  input  32  operand A.
REQ-007 reqN_b_i (N=0,1)  input  32  operand B.
REQ-008 reqN_op_i (N=0,1)  input  alu_op_t  ALU operation.
REQ-009 reqN_tag_i (N=0,1)  input  TAG_W  opaque tag, echoed with the result.
REQ-010 res_valid_o  output  1  result register holds a valid result.
REQ-011 res_ready_i  input  1  consumer takes the result this cycle.
REQ-012 res_data_o  output  32  ALU result.
REQ-013 res_src_o  output  1  index of the requester that issued the result.
REQ-014 res_tag_o  output  TAG_W  tag of the issuing operation.

Function
REQ-015 accept = !res_valid_o || res_ready_i; no requester is granted when accept is 0.
REQ-016 Only one valid requester while accept=1: that requester is granted.
REQ-017 Both requesters valid while accept=1: the requester other than the last-granted one (rr_last) is granted.
REQ-018 reqN_ready_o = accept && grant==N; at most one ready is high per cycle.
REQ-019 reqN_ready_o may depend combinationally on reqN_valid_i, the other requester's valid, res_ready_i and state.
REQ-020 Transfer = reqN_valid_i && reqN_ready_o; rr_last becomes N on a transfer and never changes otherwise.
REQ-021 The granted requester's a/b/op drive the single shared ALU.
REQ-022 On a transfer, at the next edge: res_data_o = ALU result, res_src_o = N, res_tag_o = tag, res_valid_o = 1 (latency 1 cycle).
REQ-023 accept=1 with no transfer: res_valid_o is 0 after the edge; data/src/tag registers hold their values.
REQ-024 res_valid_o=1 and res_ready_i=0: all res_* outputs stay stable and both ready outputs are 0.
REQ-025 Result drained and new transfer in the same cycle: res_valid_o stays 1 with the new result, giving one op per cycle sustained.
REQ-026 An unsupported op code returns 0 (ALU default) and completes normally; it is not flagged.
REQ-027 Requesters keep valid and payload stable until ready; the arbiter does not check this.

Reset
REQ-028 While rst_i=1 at a clock edge: res_valid_o=0, res_data_o=0, res_src_o=0, res_tag_o=0, rr_last=1.
REQ-029 reqN_ready_o is 0 in any cycle where rst_i=1.
REQ-030 A result pending when reset asserts is discarded; an offered operation is not accepted.
REQ-031 With rr_last=1 after reset, requester 0 wins the first tie.

Structure
REQ-032 alu_op_t stays in PipeTypes; add arb_src_t (1-bit requester index) and ARB_NUM_REQ=2 there.
REQ-033 Instantiate the existing alu exactly once as the only sub-module; arbitration, mux and result register stay in alu_arbiter.

Verification
REQ-034 After reset, req0 ADD 5+7 tag 3 alone, res_ready_i=1 -> next cycle res_valid_o=1, data 12, src 0, tag 3.
REQ-035 Both valid for 4 cycles (req0 SUB 10-3, req1 SLL 1<<4), res_ready_i=1 -> grants 0,1,0,1; results 7,16,7,16 on consecutive cycles.
REQ-036 req1 XOR result held with res_ready_i=0 for 3 cycles, req0 valid -> outputs stable, req0_ready_o=0; ready rises in the cycle res_ready_i=1 and req0's result follows with no bubble.
REQ-037 rst_i=1 while res_valid_o=1 and req1 valid -> after the edge res_valid_o=0, no transfer; next tie grants req0.
REQ-038 SLT 0xFFFFFFFF vs 1 -> data 1; SLTU same operands -> data 0; SRA 0x80000000 by 31 -> 0xFFFFFFFF.
